photon_deadlock_report_ctrl: RTL and testbench
==============================================

Name: photon_deadlock_report_ctrl

Overview:
Collects the per-instance `block` outputs of the photon pipeline's HLS deadlock monitors (one per dataflow process). It qualifies each with a programmable persistence threshold and arbitrates round-robin among the qualified monitors. Each qualified event is serialised onto one valid/ready report channel read by the control/status register block. It also drives a sticky summary `deadlock` flag for the interrupt line.

Parameters:
- N_MON, 4, number of monitored instances (2..16).
- CNT_W, 16, width of the per-monitor blocked-cycle counter and of the threshold.
- IDX_W, 4, width of the report index; must satisfy 2^IDX_W >= N_MON.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- block_in  in  N_MON  bit i = `block` output of monitor i.
- cfg_enable  in  1  1 = arbitration and reporting enabled; counting always runs.
- cfg_threshold  in  CNT_W  consecutive blocked cycles needed to qualify; 0 is treated as 1.
- clear  in  1  single-cycle pulse; clears counters, pending bits and `deadlock`.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts the report.
- report_idx  out  IDX_W  index of the monitor being reported.
- report_count  out  CNT_W  that monitor's counter value, snapshotted at grant.
- pending  out  N_MON  qualified but not-yet-reported monitors.
- deadlock  out  1  sticky: set when any pending bit has ever been set since the last clear.

Behaviour:
- Reset: all outputs 0, counters 0, rr_ptr 0, FSM in IDLE.
- Counter i:
  - block_in[i]=1: next = cnt+1, saturating at 2^CNT_W-1.
  - block_in[i]=0: next = 0.
- Qualification: pending[i] sets on the edge where cnt[i] goes from thr-1 to thr (thr = max(cfg_threshold,1)).
  - Fires once per blocked episode.
  - Raising the threshold mid-episode above the current count allows one later crossing. Lowering it below the current count never fires for that episode.
- Latency: block_in[i] high on cycles 0..T-1 gives pending[i]=1 on cycle T and deadlock=1 on cycle T. With the FSM idle and cfg_enable=1, report_valid=1 on cycle T+1.
- FSM states: IDLE, REPORT.
  - IDLE: if cfg_enable and |pending, grant the first set bit searching upward from rr_ptr (mod N_MON). Register report_idx and report_count = cnt[grant]. Go to REPORT.
  - REPORT: report_valid=1; report_idx and report_count held stable until the handshake. On report_valid & report_ready:
    - clear pending[idx];
    - rr_ptr <= (idx+1) mod N_MON;
    - go to IDLE; report_valid=0 next cycle.
  - Minimum one idle cycle between reports.
- cfg_enable falling during REPORT does not abort the current report; no new grants are made while it is low.
- Pending set and handshake-clear on the same index in the same cycle: set wins.
- clear: has priority over everything except reset.
  - Next cycle: counters=0, pending=0, deadlock=0, FSM=IDLE, report_valid=0. This abort is the only permitted valid drop without a handshake.
  - rr_ptr is preserved.
- deadlock: set whenever any pending bit sets; cleared only by clear or reset.
- No arithmetic wrap: counters saturate.

Decomposition:
- Package photon_dlmon_pkg holds:
  - FSM state enum (IDLE, REPORT);
  - defaults for N_MON and CNT_W;
  - report struct {idx, count}.
- Sub-module photon_dlmon_rr_arbiter: combinational round-robin priority search, taking req[N_MON] and rr_ptr and returning grant_valid and grant_idx. Reusable elsewhere in the photon design.

Test Plan:
1. thr=4, block_in[2] high for 6 cycles starting cycle 0 -> pending[2]=1 and deadlock=1 at cycle 4; report_valid at cycle 5 with idx=2, count=5; ready=1 -> pending=0. Only one report.
2. thr=2, block_in[0] and block_in[3] rise together, ready always 1 -> reports idx=0 then idx=3, one idle cycle apart. A repeat episode on both afterwards reports idx=3 first? No: with rr_ptr=0 after the idx=3 grant it reports 0 then 3; with rr_ptr=1 it reports 3 then 0. Check both.
3. Backpressure: ready=0 for 10 cycles during REPORT -> valid, idx and count stable throughout; handshake on ready=1; a new qualifying monitor during the stall stays in pending and is reported next.
4. clear pulsed while report_valid=1 -> next cycle valid=0, pending=0, deadlock=0, counters=0; rr_ptr unchanged.
5. cfg_enable=0, monitor 1 qualifies -> pending[1]=1 and deadlock=1 but no valid; enable=1 -> report idx=1 one cycle later.
6. cfg_threshold=0 with a single-cycle block_in[1] pulse -> qualifies (thr=1). With CNT_W=4 and block held for 40 cycles -> counter saturates at 15 with no wrap and no second report.

Source files
------------

// File: rtl/photon_dlmon_pkg.sv
// Shared types and default sizing for the photon deadlock-monitor report path.
package photon_dlmon_pkg;

    localparam int N_MON_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int IDX_W_DEF = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] idx;
        logic [CNT_W_DEF-1:0] count;
    } report_t;

endpackage

// File: rtl/photon_dlmon_rr_arbiter.sv
// Combinational round-robin search: first set req bit at or above rr_ptr, wrapping mod N_MON.
// Zero latency; no flow control, the caller decides when a grant is taken.
module photon_dlmon_rr_arbiter #(
    parameter int N_MON = 4,
    parameter int IDX_W = 4
) (
    input  logic [N_MON-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    logic [2*N_MON-1:0] w_rot;
    int                 w_sum;

    assign w_rot = {req, req} >> rr_ptr;

    // Walk downward so the lowest rotated offset (closest to rr_ptr) wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_sum       = 0;
        for (int k = N_MON - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = int'(rr_ptr) + k;
                if (w_sum >= N_MON) begin
                    w_sum = w_sum - N_MON;
                end
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/photon_deadlock_report_ctrl.sv
// Qualifies monitor block signals against a persistence threshold and serialises reports round-robin.
// Report valid one cycle after qualification; idx/count held under backpressure, clear aborts.
module photon_deadlock_report_ctrl
    import photon_dlmon_pkg::*;
#(
    parameter int N_MON = N_MON_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_MON-1:0] block_in,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_threshold,
    input  logic             clear,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [IDX_W-1:0] report_idx,
    output logic [CNT_W-1:0] report_count,
    output logic [N_MON-1:0] pending,
    output logic             deadlock
);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] count;
    } rep_t;

    logic [CNT_W-1:0] r_cnt     [N_MON];
    logic [CNT_W-1:0] w_cnt_nxt [N_MON];
    logic [CNT_W-1:0] w_thr;
    logic [CNT_W-1:0] w_grant_cnt;
    logic [N_MON-1:0] w_hit;
    logic [N_MON-1:0] w_hs_mask;
    logic [N_MON-1:0] r_pending;
    logic             r_deadlock;
    logic [IDX_W-1:0] r_rr_ptr;
    rep_t             r_rep;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_grant_vld;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_load;
    logic             w_hs;

    assign w_thr = (cfg_threshold == '0) ? CNT_W'(1) : cfg_threshold;

    // Qualify on the exact thr-1 -> thr step so each blocked episode fires at most once.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_MON; i++) begin
            w_cnt_nxt[i] = '0;
            if (block_in[i]) begin
                w_cnt_nxt[i] = (r_cnt[i] == '1) ? r_cnt[i] : r_cnt[i] + CNT_W'(1);
            end
            w_hit[i] = block_in[i] && (r_cnt[i] == w_thr - CNT_W'(1));
        end
    end

    photon_dlmon_rr_arbiter #(
        .N_MON (N_MON),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (r_pending),
        .rr_ptr      (r_rr_ptr),
        .grant_valid (w_grant_vld),
        .grant_idx   (w_grant_idx)
    );

    // Snapshot the value the counter takes on the grant edge, i.e. what it reads in the first REPORT cycle.
    always_comb begin
        w_grant_cnt = '0;
        w_hs_mask   = '0;
        for (int i = 0; i < N_MON; i++) begin
            if (w_grant_idx == IDX_W'(i)) begin
                w_grant_cnt = w_cnt_nxt[i];
            end
            w_hs_mask[i] = w_hs && (r_rep.idx == IDX_W'(i));
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_hs         = 1'b0;
        report_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_enable && w_grant_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                report_valid = 1'b1;
                if (report_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_MON; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending  <= '0;
            r_deadlock <= 1'b0;
            r_rr_ptr   <= '0;
            r_rep      <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_MON; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending  <= '0;
            r_deadlock <= 1'b0;
        end else begin
            for (int i = 0; i < N_MON; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_pending  <= (r_pending & ~w_hs_mask) | w_hit;
            r_deadlock <= r_deadlock | (|w_hit);
            if (w_load) begin
                r_rep.idx   <= w_grant_idx;
                r_rep.count <= w_grant_cnt;
            end
            if (w_hs) begin
                r_rr_ptr <= (r_rep.idx == IDX_W'(N_MON - 1)) ? '0 : r_rep.idx + IDX_W'(1);
            end
        end
    end

    assign report_idx   = r_rep.idx;
    assign report_count = r_rep.count;
    assign pending      = r_pending;
    assign deadlock     = r_deadlock;

endmodule

// File: tb/tb_photon_deadlock_report_ctrl.sv
// Randomised and directed stimulus against a queue-based reference model of the deadlock report controller.
module tb_photon_deadlock_report_ctrl;

    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int IW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  block_in;
    logic          cfg_enable;
    logic [CW-1:0] cfg_threshold;
    logic          clear;
    logic          report_valid;
    logic          report_ready;
    logic [IW-1:0] report_idx;
    logic [CW-1:0] report_count;
    logic [N-1:0]  pending;
    logic          deadlock;

    photon_deadlock_report_ctrl #(
        .N_MON (N),
        .CNT_W (CW),
        .IDX_W (IW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .block_in      (block_in),
        .cfg_enable    (cfg_enable),
        .cfg_threshold (cfg_threshold),
        .clear         (clear),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_idx    (report_idx),
        .report_count  (report_count),
        .pending       (pending),
        .deadlock      (deadlock)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, advanced once per rising edge.
    int m_cnt  [N];
    int m_pend [N];
    int m_dl;
    int m_busy;
    int m_rr;
    int m_cur;
    int m_live;
    int exp_idx_q [$];
    int exp_cnt_q [$];

    int mt_thr;
    int mt_nc  [N];
    int mt_hit [N];
    int mt_g;
    int mt_j;
    int mt_any;

    function automatic int pend_vec();
        int v = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] != 0) v = v | (1 << i);
        end
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        m_dl = 0; m_busy = 0; m_rr = 0; m_cur = 0; m_live = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_pend[i] = 0;
        end
        forever begin
            @(posedge clock);
            if (!reset) begin
                for (int i = 0; i < N; i++) begin
                    m_cnt[i] = 0;
                    m_pend[i] = 0;
                end
                m_dl = 0; m_busy = 0; m_rr = 0; m_cur = 0;
                exp_idx_q.delete();
                exp_cnt_q.delete();
            end else if (clear) begin
                if (m_busy != 0 && exp_idx_q.size() > 0) begin
                    void'(exp_idx_q.pop_back());
                    void'(exp_cnt_q.pop_back());
                end
                for (int i = 0; i < N; i++) begin
                    m_cnt[i] = 0;
                    m_pend[i] = 0;
                end
                m_dl = 0; m_busy = 0;
            end else begin
                mt_thr = (cfg_threshold == 0) ? 1 : int'(cfg_threshold);
                mt_any = 0;
                for (int i = 0; i < N; i++) begin
                    mt_nc[i]  = block_in[i] ? ((m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1) : 0;
                    mt_hit[i] = (block_in[i] && m_cnt[i] < mt_thr && mt_nc[i] >= mt_thr) ? 1 : 0;
                    mt_any    = mt_any | mt_hit[i];
                end
                if (m_busy != 0 && report_ready) begin
                    m_pend[m_cur] = 0;
                    m_rr   = (m_cur + 1) % N;
                    m_busy = 0;
                end else if (m_busy == 0 && cfg_enable && pend_vec() != 0) begin
                    mt_g = -1;
                    for (int k = 0; k < N; k++) begin
                        mt_j = (m_rr + k) % N;
                        if (mt_g < 0 && m_pend[mt_j] != 0) mt_g = mt_j;
                    end
                    m_busy = 1;
                    m_cur  = mt_g;
                    exp_idx_q.push_back(mt_g);
                    exp_cnt_q.push_back(mt_nc[mt_g]);
                end
                for (int i = 0; i < N; i++) begin
                    if (mt_hit[i] != 0) m_pend[i] = 1;
                    m_cnt[i] = mt_nc[i];
                end
                if (mt_any != 0) m_dl = 1;
            end
            m_live = 1;
        end
    end

    // Monitor: compare on the falling edge, pop the scoreboard on each handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (m_live != 0) begin
                chk("report_valid", int'(report_valid), m_busy);
                chk("pending", int'(pending), pend_vec());
                chk("deadlock", int'(deadlock), m_dl);
                if (!reset) begin
                    chk("reset_idx", int'(report_idx), 0);
                    chk("reset_count", int'(report_count), 0);
                end else if (report_valid && report_ready && !clear) begin
                    chk("scoreboard_has_entry", (exp_idx_q.size() > 0) ? 1 : 0, 1);
                    if (exp_idx_q.size() > 0) begin
                        chk("report_idx", int'(report_idx), exp_idx_q.pop_front());
                        chk("report_count", int'(report_count), exp_cnt_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; block_in = '0; cfg_enable = 1'b0; cfg_threshold = '0;
        clear = 1'b0; report_ready = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);

        // Single monitor, threshold 4, six blocked cycles.
        cfg_enable = 1'b1; cfg_threshold = 4'd4; report_ready = 1'b1;
        block_in = 4'b0100; tick(6);
        block_in = 4'b0000; tick(6);

        // Simultaneous qualification, then the same after rr_ptr moves to 1.
        cfg_threshold = 4'd2;
        block_in = 4'b1001; tick(3);
        block_in = 4'b0000; tick(8);
        block_in = 4'b1001; tick(3);
        block_in = 4'b0000; tick(8);
        block_in = 4'b0001; tick(3);
        block_in = 4'b0000; tick(6);
        block_in = 4'b1001; tick(3);
        block_in = 4'b0000; tick(8);

        // Backpressure with a second monitor qualifying during the stall.
        report_ready = 1'b0;
        block_in = 4'b0010; tick(3);
        block_in = 4'b0100; tick(3);
        block_in = 4'b0000; tick(6);
        report_ready = 1'b1; tick(8);

        // Clear while a report is outstanding.
        report_ready = 1'b0;
        block_in = 4'b1000; tick(4);
        clear = 1'b1; tick(1);
        clear = 1'b0; block_in = 4'b0000; report_ready = 1'b1; tick(4);
        block_in = 4'b0110; tick(3);
        block_in = 4'b0000; tick(8);

        // Reporting disabled while a monitor qualifies.
        cfg_enable = 1'b0;
        block_in = 4'b0010; tick(4);
        block_in = 4'b0000; tick(4);
        cfg_enable = 1'b1; tick(6);

        // Threshold 0 behaves as 1; long episode saturates the counter.
        cfg_threshold = 4'd0;
        block_in = 4'b0010; tick(1);
        block_in = 4'b0000; tick(4);
        cfg_threshold = 4'd14;
        block_in = 4'b0001; tick(40);
        block_in = 4'b0000; tick(5);

        // Random traffic with threshold changes, enable toggles and occasional clears.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5, 0) == 0) block_in[i] = ~block_in[i];
            end
            report_ready = ($urandom_range(2, 0) != 0);
            clear        = ($urandom_range(199, 0) == 0);
            if ($urandom_range(99, 0) == 0) cfg_enable = ~cfg_enable;
            if ($urandom_range(49, 0) == 0) cfg_threshold = CW'($urandom_range(6, 0));
            tick(1);
        end

        block_in = '0; clear = 1'b0; cfg_enable = 1'b1; report_ready = 1'b1;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
